// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types, sizes and butterfly address/twiddle generation
// for the NTT sequencer.
package ntt_pkg;
    localparam int LOGN = 8;
    localparam int N = 1 << LOGN;
    localparam int KYBER_LAYERS = 7;
    localparam int DIL_LAYERS = 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    typedef logic [LOGN-1:0] coef_addr_t;
    typedef logic [LOGN-1:0] tw_idx_t;
    typedef logic [LOGN-2:0] bfly_cnt_t;
    typedef logic [2:0] layer_t;

    typedef struct packed {
        coef_addr_t a;
        coef_addr_t b;
        tw_idx_t idx;
    } bfly_t;

    typedef struct packed {
        logic v;
        coef_addr_t a;
        coef_addr_t b;
    } wr_ent_t;

    // Inverse runs len upward; Kyber skips the len=1 layer in both directions.
    function automatic bfly_t bfly_addr(layer_t l, bfly_cnt_t bc, logic inv, logic kyber);
        layer_t s;
        coef_addr_t len, bc8, g, grp;
        bfly_t r;
        s = inv ? l + {2'b0, kyber} : 3'd7 - l;
        len = coef_addr_t'(1) << s;
        bc8 = {1'b0, bc};
        g = bc8 >> s;
        grp = coef_addr_t'(N / 2) >> s;
        r.a = ((g << s) << 1) | (bc8 & (len - 1'b1));
        r.b = r.a + len;
        r.idx = inv ? (grp << 1) - 8'd1 - g : grp + g;
        return r;
    endfunction
endpackage

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: control, butterfly-issue and write-back signals of the NTT sequencer.
interface ntt_ctrl_if;
    import ntt_pkg::*;
    logic start_i, sel_red_i, sel_butterfly_i, stall_i;
    logic busy_o, done_o, rd_en_o, sel_red_o, sel_butterfly_o, wr_en_o;
    coef_addr_t rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    tw_idx_t twiddle_idx_o;

    modport master (
        input start_i, sel_red_i, sel_butterfly_i, stall_i,
        output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
        output sel_red_o, sel_butterfly_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        output start_i, sel_red_i, sel_butterfly_i, stall_i,
        input busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
        input sel_red_o, sel_butterfly_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/ntt_addr_delay.sv
// ntt_addr_delay: LATENCY-deep shift register carrying issue valid and operand
// addresses to the write-back port; holds while shift is low.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input logic clk_i,
    input logic rst_ni,
    input logic shift,
    input wr_ent_t d,
    output wr_ent_t q
);
    wr_ent_t pipe [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else if (shift) begin
            pipe[0] <= d;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LATENCY-1];
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: walks every layer of an in-place forward/inverse NTT (Kyber or Dilithium),
// issuing one butterfly per cycle and replaying its addresses LATENCY cycles later.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input logic clk_i,
    input logic rst_ni,
    ntt_ctrl_if.master bus
);
    localparam logic [7:0] FLUSH_LAST = 8'(LATENCY - 1);

    state_t state, state_n;
    layer_t l, l_n, last;
    bfly_cnt_t bc, bc_n;
    logic [7:0] fc, fc_n;
    logic kyber, kyber_n, inv, inv_n, rd_en;
    bfly_t cur, nxt;
    wr_ent_t rd_ent, wr_ent;

    assign last = kyber ? layer_t'(KYBER_LAYERS - 1) : layer_t'(DIL_LAYERS - 1);

    // Registers describe the butterfly shown this cycle, so addresses come from next-state counters.
    always_comb begin
        state_n = state;
        l_n = l;
        bc_n = bc;
        fc_n = fc;
        kyber_n = kyber;
        inv_n = inv;
        if (!bus.stall_i) begin
            unique case (state)
                IDLE: if (bus.start_i) begin
                    state_n = RUN;
                    l_n = '0;
                    bc_n = '0;
                    kyber_n = bus.sel_red_i;
                    inv_n = bus.sel_butterfly_i;
                end
                RUN: if (&bc) begin
                    state_n = FLUSH;
                    fc_n = '0;
                end else bc_n = bc + 1'b1;
                FLUSH: if (fc == FLUSH_LAST) begin
                    state_n = (l == last) ? DONE : RUN;
                    l_n = (l == last) ? l : l + 1'b1;
                    bc_n = '0;
                end else fc_n = fc + 1'b1;
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign nxt = bfly_addr(l_n, bc_n, inv_n, kyber_n);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            l <= '0;
            bc <= '0;
            fc <= '0;
            kyber <= 1'b0;
            inv <= 1'b0;
            cur <= '0;
        end else begin
            state <= state_n;
            l <= l_n;
            bc <= bc_n;
            fc <= fc_n;
            kyber <= kyber_n;
            inv <= inv_n;
            cur <= nxt;
        end
    end

    assign rd_en = state == RUN && !bus.stall_i;
    assign rd_ent = '{v: rd_en, a: cur.a, b: cur.b};

    ntt_addr_delay #(.LATENCY(LATENCY)) u_delay (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .shift(!bus.stall_i),
        .d(rd_ent),
        .q(wr_ent)
    );

    assign bus.busy_o = state != IDLE;
    assign bus.done_o = state == DONE && !bus.stall_i;
    assign bus.rd_en_o = rd_en;
    assign bus.rd_addr_a_o = cur.a;
    assign bus.rd_addr_b_o = cur.b;
    assign bus.twiddle_idx_o = cur.idx;
    assign bus.sel_red_o = kyber;
    assign bus.sel_butterfly_o = inv;
    assign bus.wr_en_o = wr_ent.v && !bus.stall_i;
    assign bus.wr_addr_a_o = wr_ent.a;
    assign bus.wr_addr_b_o = wr_ent.b;
endmodule
